// File: rtl/snap_phase_seq.sv
// -----------------------------------------------------------------------------
// snap_phase_seq
//
// Capture sequencer for the phase snapshot path. A software control word arms
// a run on a rising start bit. The run waits for a channelizer frame boundary,
// then keeps one of every dec+1 phase samples of the selected channel. Each
// kept sample is written into the snapshot BRAM together with a 16-bit frame
// timestamp, until len+1 samples have been stored.
//
// Ports
//   user_clk     : sole clock, rising edge
//   user_rst     : asynchronous active-high reset
//   ctrl_word    : [0] start, [1] abort, [CH_W+1:2] sel,
//                  [CH_W+ADDR_W+1:CH_W+2] len (samples = len+1),
//                  [31:24] dec (keep 1 of every dec+1)
//   ch_idx       : channel index of the current phase sample
//   phase_in     : phase sample
//   phase_valid  : qualifies ch_idx / phase_in
//   bram_addr    : snapshot BRAM write address
//   bram_din     : {frame_ts[15:0], phase[15:0]}
//   bram_we      : snapshot BRAM write enable
//   busy         : run armed (waiting for sync or capturing)
//   done         : run finished, waiting for start to drop
//   status_out   : {done, busy, 14'b0, wr_cnt[15:0]}
// -----------------------------------------------------------------------------
module snap_phase_seq #(
  parameter int CH_W   = 9,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_word,
  input  logic [CH_W-1:0]   ch_idx,
  input  logic [15:0]       phase_in,
  input  logic              phase_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = {CH_W{1'b1}};
  localparam logic [CH_W-1:0] SYNC_CH = {CH_W{1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Control word fields
  // ---------------------------------------------------------------------------
  logic              ctrl_start;
  logic              ctrl_abort;
  logic [CH_W-1:0]   ctrl_sel;
  logic [ADDR_W-1:0] ctrl_len;
  logic [7:0]        ctrl_dec;

  assign ctrl_start = ctrl_word[0];
  assign ctrl_abort = ctrl_word[1];
  assign ctrl_sel   = ctrl_word[CH_W+1:2];
  assign ctrl_len   = ctrl_word[CH_W+ADDR_W+1:CH_W+2];
  assign ctrl_dec   = ctrl_word[31:24];

  // Bits between the len field and the dec field carry no meaning.
  generate
    if (CH_W + ADDR_W + 2 <= 23) begin : g_spare_bits
      logic spare_unused;
      assign spare_unused = ^ctrl_word[23:CH_W+ADDR_W+2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic              start_q,     start_d;
  logic [CH_W-1:0]   sel_q,       sel_d;
  logic [ADDR_W-1:0] len_q,       len_d;
  logic [7:0]        dec_q,       dec_d;
  logic [7:0]        dec_cnt_q,   dec_cnt_d;
  // One bit wider than the address so a full-depth run does not wrap.
  logic [ADDR_W:0]   wr_cnt_q,    wr_cnt_d;
  logic [15:0]       frame_ts_q,  frame_ts_d;
  logic              bram_we_q,   bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]       bram_din_q,  bram_din_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  logic start_edge;
  logic frame_end;
  logic sel_hit;
  logic last_write;

  assign start_edge = ctrl_start & ~start_q;
  assign frame_end  = phase_valid && (ch_idx == LAST_CH);
  assign sel_hit    = phase_valid && (ch_idx == sel_q);
  assign last_write = (wr_cnt_q == {1'b0, len_q});

  always_comb begin
    state_d     = state_q;
    start_d     = ctrl_start;
    sel_d       = sel_q;
    len_d       = len_q;
    dec_d       = dec_q;
    dec_cnt_d   = dec_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    frame_ts_d  = frame_end ? (frame_ts_q + 16'd1) : frame_ts_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          sel_d     = ctrl_sel;
          len_d     = ctrl_len;
          dec_d     = ctrl_dec;
          dec_cnt_d = 8'd0;
          wr_cnt_d  = '0;
          state_d   = ST_WAIT_SYNC;
        end
      end

      // The channel-0 sample that marks the boundary is consumed by the
      // transition itself, so capturing starts with the following sample.
      ST_WAIT_SYNC: begin
        if (phase_valid && (ch_idx == SYNC_CH)) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (sel_hit) begin
          if (dec_cnt_q == 8'd0) begin
            bram_we_d   = 1'b1;
            bram_addr_d = wr_cnt_q[ADDR_W-1:0];
            bram_din_d  = {frame_ts_q, phase_in};
            wr_cnt_d    = wr_cnt_q + CNT_ONE;
            dec_cnt_d   = dec_q;
            if (last_write) begin
              state_d = ST_DONE;
            end
          end else begin
            dec_cnt_d = dec_cnt_q - 8'd1;
          end
        end
      end

      // Leaving DONE needs start low, so a held start bit cannot re-arm.
      ST_DONE: begin
        if (!ctrl_start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything decided above: no start is accepted, no
    // write leaves, and the run counters keep their current values.
    if (ctrl_abort) begin
      state_d     = ST_IDLE;
      sel_d       = sel_q;
      len_d       = len_q;
      dec_d       = dec_q;
      dec_cnt_d   = dec_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
    end

    busy_d = (state_d == ST_WAIT_SYNC) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      sel_q       <= '0;
      len_q       <= '0;
      dec_q       <= 8'd0;
      dec_cnt_q   <= 8'd0;
      wr_cnt_q    <= '0;
      frame_ts_q  <= 16'd0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      dec_q       <= dec_d;
      dec_cnt_q   <= dec_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_ts_q  <= frame_ts_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [15:0] wr_cnt16;

  generate
    if (ADDR_W + 1 >= 16) begin : g_cnt_trunc
      assign wr_cnt16 = wr_cnt_q[15:0];
    end else begin : g_cnt_ext
      assign wr_cnt16 = {{(15 - ADDR_W){1'b0}}, wr_cnt_q};
    end
  endgenerate

  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status_out = {done_q, busy_q, 14'b0, wr_cnt16};

endmodule

// File: tb/tb_snap_phase_seq.sv
// -----------------------------------------------------------------------------
// tb_snap_phase_seq
//
// Directed sequence of capture scenarios over a randomized phase stream. For
// each scenario the expected BRAM writes, busy/done and status are derived
// from the stimulus tables by scanning them (find the start edge, the sync
// sample, the qualifying samples, keep every (dec+1)-th) and then compared
// against the design every cycle.
// -----------------------------------------------------------------------------
module tb_snap_phase_seq;

  localparam int CH_W   = 9;
  localparam int ADDR_W = 10;
  localparam int MAXC   = 4000;
  localparam int INF    = 1 << 30;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl_word;
  logic [CH_W-1:0]   ch_idx;
  logic [15:0]       phase_in;
  logic              phase_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;
  logic              bram_we;
  logic              busy;
  logic              done;
  logic [31:0]       status_out;

  snap_phase_seq #(.CH_W(CH_W), .ADDR_W(ADDR_W)) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .ctrl_word   (ctrl_word),
    .ch_idx      (ch_idx),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_we     (bram_we),
    .busy        (busy),
    .done        (done),
    .status_out  (status_out)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus tables, one entry per cycle of the current scenario.
  bit              v_a  [MAXC];
  logic [CH_W-1:0] ch_a [MAXC];
  logic [15:0]     ph_a [MAXC];
  logic [31:0]     cw_a [MAXC];

  // Expected outputs observed just after the edge that ends cycle c.
  bit                e_we   [MAXC];
  bit                e_busy [MAXC];
  bit                e_done [MAXC];
  logic [ADDR_W-1:0] e_addr [MAXC];
  logic [31:0]       e_din  [MAXC];
  int                e_wr   [MAXC];
  logic [15:0]       ts_at  [MAXC];
  int                wr_pos [$];

  // State carried from one scenario to the next.
  logic [15:0] ts_m;
  int          wr_m;
  bit          last_bit0;
  int          ch_next;

  task automatic chk(string tag, int cyc, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ctrl(bit st, bit ab, int sel, int len, int dec);
    logic [31:0] w;
    w = '0;
    w[0] = st;
    w[1] = ab;
    w[CH_W+1:2] = sel[CH_W-1:0];
    w[CH_W+ADDR_W+1:CH_W+2] = len[ADDR_W-1:0];
    w[31:24] = dec[7:0];
    return w;
  endfunction

  // Continuous channel sweep with random invalid cycles (gap percent).
  task automatic gen_stream(int n, int gap);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 99) < gap) begin
        v_a[c]  = 1'b0;
        ch_a[c] = CH_W'($urandom);
      end else begin
        v_a[c]  = 1'b1;
        ch_a[c] = CH_W'(ch_next);
        ch_next = (ch_next + 1) % (1 << CH_W);
      end
      ph_a[c] = 16'($urandom);
    end
  endtask

  task automatic fill_ctrl(int from, int to, logic [31:0] w);
    for (int c = from; c <= to; c++) cw_a[c] = w;
  endtask

  task automatic compute(int n);
    int s, a, sync_c, done_c, drop, k, cnt, len, dec;
    logic [15:0] ts;
    logic [CH_W-1:0] sel;
    bit prev;

    ts = ts_m;
    for (int c = 0; c < n; c++) begin
      ts_at[c] = ts;
      if (v_a[c] && ch_a[c] == '1) ts = ts + 16'd1;
      e_we[c]   = 1'b0;
      e_busy[c] = 1'b0;
      e_done[c] = 1'b0;
      e_addr[c] = '0;
      e_din[c]  = '0;
      e_wr[c]   = wr_m;
    end
    wr_pos.delete();

    s = -1;
    for (int c = 0; c < n; c++) begin
      prev = (c == 0) ? last_bit0 : cw_a[c-1][0];
      if (s < 0 && cw_a[c][0] && !prev && !cw_a[c][1]) s = c;
    end
    if (s < 0) return;

    sel = cw_a[s][CH_W+1:2];
    len = int'(cw_a[s][CH_W+ADDR_W+1:CH_W+2]);
    dec = int'(cw_a[s][31:24]);

    a = INF;
    for (int c = s; c < n; c++) if (a == INF && cw_a[c][1]) a = c;

    sync_c = INF;
    for (int c = s + 1; c < n && c < a; c++)
      if (sync_c == INF && v_a[c] && ch_a[c] == '0) sync_c = c;

    done_c = INF;
    k = 0;
    for (int c = sync_c + 1; c < n && c < a && done_c == INF; c++) begin
      if (v_a[c] && ch_a[c] == sel) begin
        if (k % (dec + 1) == 0) begin
          e_we[c]   = 1'b1;
          e_addr[c] = ADDR_W'(wr_pos.size());
          e_din[c]  = {ts_at[c], ph_a[c]};
          if (wr_pos.size() == len) done_c = c;
          wr_pos.push_back(c);
        end
        k++;
      end
    end

    drop = INF;
    for (int c = done_c + 1; c < n; c++) if (drop == INF && !cw_a[c][0]) drop = c;

    cnt = 0;
    for (int c = s; c < n; c++) begin
      if (e_we[c]) cnt++;
      e_wr[c]   = cnt;
      e_busy[c] = (c < done_c) && (c < a);
      e_done[c] = (c >= done_c) && (c < drop) && (c < a);
    end
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) begin
      ctrl_word   = cw_a[c];
      ch_idx      = ch_a[c];
      phase_in    = ph_a[c];
      phase_valid = v_a[c];
      @(posedge user_clk);
      #1;
      chk("bram_we", c, 32'(bram_we), 32'(e_we[c]));
      chk("busy", c, 32'(busy), 32'(e_busy[c]));
      chk("done", c, 32'(done), 32'(e_done[c]));
      chk("status", c, status_out,
          {e_done[c], e_busy[c], 14'b0, 16'(e_wr[c])});
      if (e_we[c]) begin
        chk("bram_addr", c, 32'(bram_addr), 32'(e_addr[c]));
        chk("bram_din", c, bram_din, e_din[c]);
      end
    end
    last_bit0 = cw_a[n-1][0];
    ts_m      = ts_at[n-1] + ((v_a[n-1] && ch_a[n-1] == '1) ? 16'd1 : 16'd0);
    wr_m      = e_wr[n-1];
  endtask

  task automatic chk_all_zero(int tag_cyc);
    chk("rst_we", tag_cyc, 32'(bram_we), 32'd0);
    chk("rst_busy", tag_cyc, 32'(busy), 32'd0);
    chk("rst_done", tag_cyc, 32'(done), 32'd0);
    chk("rst_status", tag_cyc, status_out, 32'd0);
    chk("rst_addr", tag_cyc, 32'(bram_addr), 32'd0);
    chk("rst_din", tag_cyc, bram_din, 32'd0);
  endtask

  initial begin
    int sel, len, dec, q2, cut;

    user_rst    = 1'b1;
    ctrl_word   = '0;
    ch_idx      = '0;
    phase_in    = '0;
    phase_valid = 1'b0;
    ts_m        = 16'd0;
    wr_m        = 0;
    last_bit0   = 1'b0;
    ch_next     = $urandom_range(0, (1 << CH_W) - 1);

    // Reset state
    repeat (2) @(posedge user_clk);
    #1;
    chk_all_zero(-1);
    user_rst = 1'b0;

    // Idle with ctrl=0: frame_ts keeps counting frames
    gen_stream(1200, 10);
    fill_ctrl(0, 1199, '0);
    compute(1200);
    run(1200);

    // sel=5, len=3, dec=0, continuous frames
    gen_stream(2520, 0);
    fill_ctrl(0, 2, mk_ctrl(0, 0, 5, 3, 0));
    fill_ctrl(3, 2499, mk_ctrl(1, 0, 5, 3, 0));
    fill_ctrl(2500, 2519, mk_ctrl(0, 0, 5, 3, 0));
    compute(2520);
    run(2520);

    // Decimation: dec=2, len=1, gaps in phase_valid
    sel = $urandom_range(1, (1 << CH_W) - 1);
    gen_stream(3220, 6);
    fill_ctrl(0, 1, mk_ctrl(0, 0, sel, 1, 2));
    fill_ctrl(2, 3199, mk_ctrl(1, 0, sel, 1, 2));
    fill_ctrl(3200, 3219, mk_ctrl(0, 0, sel, 1, 2));
    compute(3220);
    run(3220);

    // sel=0, start mid-frame: sync frame's channel 0 is skipped
    len = $urandom_range(0, 2);
    gen_stream(2920, 6);
    fill_ctrl(0, 4, mk_ctrl(0, 0, 0, len, 0));
    fill_ctrl(5, 2899, mk_ctrl(1, 0, 0, len, 0));
    fill_ctrl(2900, 2919, mk_ctrl(0, 0, 0, len, 0));
    compute(2920);
    run(2920);

    // Abort after 2 writes; start toggled during abort is ignored
    sel = $urandom_range(1, (1 << CH_W) - 1);
    gen_stream(3600, 6);
    fill_ctrl(0, 3, mk_ctrl(0, 0, sel, 7, 0));
    fill_ctrl(4, 3599, mk_ctrl(1, 0, sel, 7, 0));
    compute(3600);
    q2 = wr_pos[1];
    fill_ctrl(q2 + 5, q2 + 10, mk_ctrl(1, 1, sel, 7, 0));
    fill_ctrl(q2 + 7, q2 + 7, mk_ctrl(0, 1, sel, 7, 0));
    fill_ctrl(q2 + 11, q2 + 700, mk_ctrl(1, 0, sel, 7, 0));
    fill_ctrl(q2 + 701, q2 + 1199, mk_ctrl(0, 0, sel, 7, 0));
    compute(q2 + 1200);
    run(q2 + 1200);

    // Start held high after DONE does not re-arm
    sel = $urandom_range(0, (1 << CH_W) - 1);
    dec = $urandom_range(0, 3);
    gen_stream(2100, 6);
    fill_ctrl(0, 1, mk_ctrl(0, 0, sel, 0, dec));
    fill_ctrl(2, 2049, mk_ctrl(1, 0, sel, 0, dec));
    fill_ctrl(2050, 2099, mk_ctrl(0, 0, sel, 0, dec));
    compute(2100);
    run(2100);

    // New run restarts wr_cnt at 0; cut right after its second write
    sel = $urandom_range(0, (1 << CH_W) - 1);
    gen_stream(3600, 6);
    fill_ctrl(0, 2, mk_ctrl(0, 0, sel, 3, 1));
    fill_ctrl(3, 3599, mk_ctrl(1, 0, sel, 3, 1));
    compute(3600);
    cut = wr_pos[1] + 1;
    run(cut);

    // Asynchronous reset mid-CAPTURE, between clock edges
    #2;
    user_rst = 1'b1;
    #1;
    chk_all_zero(-2);
    ctrl_word   = '0;
    phase_valid = 1'b0;
    @(posedge user_clk);
    #1;
    user_rst  = 1'b0;
    ts_m      = 16'd0;
    wr_m      = 0;
    last_bit0 = 1'b0;

    // Short run after reset: timestamps restart from 0
    sel = $urandom_range(0, (1 << CH_W) - 1);
    gen_stream(1400, 6);
    fill_ctrl(0, 1, mk_ctrl(0, 0, sel, 0, 0));
    fill_ctrl(2, 1349, mk_ctrl(1, 0, sel, 0, 0));
    fill_ctrl(1350, 1399, mk_ctrl(0, 0, sel, 0, 0));
    compute(1400);
    run(1400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
